// File: rtl/mem_access.sv
// MEM pipeline stage: performs loads/stores on a req/ack bus with byte-lane
// steering, load sign/zero extension, misalignment detection and bus timeout.
// Handshake: bus_req/bus_we/bus_addr/bus_be/bus_wdata are held stable from the
// cycle bus_req rises until the cycle bus_ack is sampled high; that cycle
// completes the access and bus_req drops on the following edge.
module mem_access #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    input  logic            en_mem,
    input  logic            mem_write,
    input  logic            mem_read_unsigned,
    input  logic [1:0]      mem_size,
    input  logic            en_wb,
    input  logic [4:0]      reg_write,
    input  logic [XLEN-1:0] pcp4,
    input  logic            use_pcp4,
    output logic            stall,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_be,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ack,
    output logic [XLEN-1:0] wb_data,
    output logic            en_wb_out,
    output logic [4:0]      reg_write_out,
    output logic [XLEN-1:0] pcp4_out,
    output logic            use_pcp4_out,
    output logic            fault,
    output logic            dbg_state
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUS = 1'b1} state_t;

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            bus_req_q, bus_we_q, fault_q;
    logic [XLEN-1:0] bus_addr_q, bus_wdata_q, wb_data_q, pcp4_out_q;
    logic [3:0]      bus_be_q;
    logic            en_wb_out_q, use_pcp4_out_q;
    logic [4:0]      reg_write_out_q;

    // Request and write-back bundle captured at accept time
    logic [XLEN-1:0] lat_addr_q, lat_pcp4_q;
    logic [1:0]      lat_size_q;
    logic            lat_unsigned_q, lat_en_wb_q, lat_use_q;
    logic [4:0]      lat_rd_q;

    logic            misaligned, accept_ok, timeout;
    logic [3:0]      be_d;
    logic [XLEN-1:0] wdata_d, load_d, lane_sh;

    assign misaligned = (mem_size == 2'd3) ||
                        (mem_size == 2'd1 && addr[0]) ||
                        (mem_size == 2'd2 && addr[1:0] != 2'b00);
    assign accept_ok  = (state_q == IDLE) && en && en_mem && !misaligned;
    assign timeout    = (state_q == BUS) && (cnt_q == CNT_MAX);
    assign stall      = accept_ok || ((state_q == BUS) && !(bus_ack || timeout));

    // Byte-lane mask and replicated store data for the incoming request
    always_comb begin
        be_d    = 4'hF;
        wdata_d = store_data;
        case (mem_size)
            2'd0: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            2'd1: begin
                be_d    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{store_data[15:0]}};
            end
            default: begin
                be_d    = 4'hF;
                wdata_d = store_data;
            end
        endcase
    end

    // Select the addressed lane of the read data and extend it to XLEN
    always_comb begin
        lane_sh = bus_rdata >> {lat_addr_q[1:0], 3'b000};
        load_d  = bus_rdata;
        case (lat_size_q)
            2'd0:    load_d = lat_unsigned_q ? {{(XLEN-8){1'b0}}, lane_sh[7:0]}
                                             : {{(XLEN-8){lane_sh[7]}}, lane_sh[7:0]};
            2'd1:    load_d = lat_unsigned_q ? {{(XLEN-16){1'b0}}, lane_sh[15:0]}
                                             : {{(XLEN-16){lane_sh[15]}}, lane_sh[15:0]};
            default: load_d = bus_rdata;
        endcase
    end

    // Stage FSM: accept/pass-through in IDLE, wait for ack or timeout in BUS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            bus_req_q       <= 1'b0;
            bus_we_q        <= 1'b0;
            bus_addr_q      <= '0;
            bus_wdata_q     <= '0;
            bus_be_q        <= 4'b0;
            wb_data_q       <= '0;
            en_wb_out_q     <= 1'b0;
            reg_write_out_q <= 5'b0;
            pcp4_out_q      <= '0;
            use_pcp4_out_q  <= 1'b0;
            fault_q         <= 1'b0;
            lat_addr_q      <= '0;
            lat_pcp4_q      <= '0;
            lat_size_q      <= 2'b0;
            lat_unsigned_q  <= 1'b0;
            lat_en_wb_q     <= 1'b0;
            lat_use_q       <= 1'b0;
            lat_rd_q        <= 5'b0;
        end else begin
            fault_q     <= 1'b0;
            en_wb_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        if (!en_mem) begin
                            wb_data_q       <= addr;
                            en_wb_out_q     <= en_wb;
                            reg_write_out_q <= reg_write;
                            pcp4_out_q      <= pcp4;
                            use_pcp4_out_q  <= use_pcp4;
                        end else if (misaligned) begin
                            fault_q <= 1'b1;
                        end else begin
                            lat_addr_q     <= addr;
                            lat_pcp4_q     <= pcp4;
                            lat_size_q     <= mem_size;
                            lat_unsigned_q <= mem_read_unsigned;
                            lat_en_wb_q    <= en_wb;
                            lat_use_q      <= use_pcp4;
                            lat_rd_q       <= reg_write;
                            bus_req_q      <= 1'b1;
                            bus_we_q       <= mem_write;
                            bus_addr_q     <= {addr[XLEN-1:2], 2'b00};
                            bus_be_q       <= be_d;
                            bus_wdata_q    <= wdata_d;
                            cnt_q          <= '0;
                            state_q        <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        bus_req_q       <= 1'b0;
                        state_q         <= IDLE;
                        wb_data_q       <= bus_we_q ? lat_addr_q : load_d;
                        en_wb_out_q     <= lat_en_wb_q;
                        reg_write_out_q <= lat_rd_q;
                        pcp4_out_q      <= lat_pcp4_q;
                        use_pcp4_out_q  <= lat_use_q;
                    end else if (timeout) begin
                        bus_req_q <= 1'b0;
                        fault_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_req       = bus_req_q;
    assign bus_we        = bus_we_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign bus_be        = bus_be_q;
    assign wb_data       = wb_data_q;
    assign en_wb_out     = en_wb_out_q;
    assign reg_write_out = reg_write_out_q;
    assign pcp4_out      = pcp4_out_q;
    assign use_pcp4_out  = use_pcp4_out_q;
    assign fault         = fault_q;
    assign dbg_state     = state_q;

endmodule
